// File: rtl/line_rasterizer.sv
// Bresenham line generator: takes one segment per start pulse and streams its
// pixels over a valid/ready interface, pulsing done after the last handshake.
module line_rasterizer #(
  parameter int COORD_W = 8
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [1:0]         dbg_state
);

  // Stream handshake: a pixel transfers on a rising edge where pix_valid and
  // pix_ready are both high; while pix_valid is high and pix_ready is low,
  // pix_x/pix_y and all internal state are held unchanged.

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EMIT, S_FIN} state_t;

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  state_t                    state_q;
  logic [COORD_W-1:0]        xs_q, ys_q, xe_q, ye_q;
  logic [COORD_W-1:0]        x_q, y_q;
  logic signed [COORD_W+1:0] dx_q, dy_q, err_q;
  logic                      sx_neg_q, sy_neg_q;
  logic                      busy_q, done_q, valid_q;

  logic [COORD_W-1:0]        adx, ady;
  logic signed [COORD_W+1:0] dx_set, dy_set, err_set;
  logic signed [COORD_W+2:0] e2;
  logic                      step_x, step_y, at_end;
  logic signed [COORD_W+1:0] err_d;
  logic [COORD_W-1:0]        x_d, y_d;

  always_comb begin
    adx     = (xe_q > xs_q) ? (xe_q - xs_q) : (xs_q - xe_q);
    ady     = (ye_q > ys_q) ? (ye_q - ys_q) : (ys_q - ye_q);
    dx_set  = $signed({2'b00, adx});
    dy_set  = -$signed({2'b00, ady});
    err_set = dx_set + dy_set;

    // e2 carries one extra bit so doubling err can never overflow.
    e2     = {err_q, 1'b0};
    step_x = (e2 >= dy_q);
    step_y = (e2 <= dx_q);
    at_end = (x_q == xe_q) && (y_q == ye_q);

    err_d = err_q;
    x_d   = x_q;
    y_d   = y_q;
    if (step_x) begin
      err_d = err_d + dy_q;
      x_d   = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
    end
    if (step_y) begin
      err_d = err_d + dx_q;
      y_d   = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= S_IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            xs_q    <= x0;
            ys_q    <= y0;
            xe_q    <= x1;
            ye_q    <= y1;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          dx_q     <= dx_set;
          dy_q     <= dy_set;
          err_q    <= err_set;
          sx_neg_q <= !(xs_q < xe_q);
          sy_neg_q <= !(ys_q < ye_q);
          x_q      <= xs_q;
          y_q      <= ys_q;
          valid_q  <= 1'b1;
          state_q  <= S_EMIT;
        end
        S_EMIT: begin
          if (valid_q && pix_ready) begin
            if (at_end) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              x_q   <= x_d;
              y_q   <= y_d;
              err_q <= err_d;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_valid = valid_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: hand-computed pixel sequences, latency,
// backpressure stability, full-span lines and mid-line reset.
module tb_line_rasterizer;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic       start;
  logic [7:0] x0, y0, x1, y1;
  logic       busy, done, pix_valid, pix_ready;
  logic [7:0] pix_x, pix_y;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int first_v, last_hs, done_at;

  line_rasterizer #(.COORD_W(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .dbg_state(dbg_state)
  );

  always #5 ACLK = ~ACLK;

  // Drive a one-cycle start; returns at the negedge of the SETUP cycle.
  task automatic start_line(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    start = 1'b1; x0 = a; y0 = b; x1 = c; y1 = d;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  // Collect handshaken pixels until done; iteration 0 is the SETUP cycle.
  task automatic collect(input logic [31:0] rpat, input int budget, input int inject_at);
    got_q.delete();
    first_v = -1; last_hs = -1; done_at = -1;
    for (int i = 0; i < budget; i++) begin
      pix_ready = (i < 32) ? rpat[i] : 1'b1;
      if (i == inject_at) begin
        start = 1'b1; x0 = 8'd9; y0 = 8'd9; x1 = 8'd9; y1 = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (pix_valid && first_v < 0) first_v = i;
      if (pix_valid && pix_ready) begin
        got_q.push_back({pix_x, pix_y});
        last_hs = i;
      end
      if (done) begin
        done_at = i;
        break;
      end
      @(negedge ACLK);
    end
    start = 1'b0;
    if (done_at < 0) begin
      checks++; failures++;
      $display("FAIL collect_timeout got=no_done exp=done_within_%0d_cycles", budget);
    end
  endtask

  task automatic test_reset();
    #1 ARESETn = 1'b0;
    #1;
    checks++;
    if ({busy, done, pix_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, pix_valid});
    end
    checks++;
    if ({pix_x, pix_y} !== 16'h0000) begin
      failures++; $display("FAIL reset_pixel got=%h exp=0000", {pix_x, pix_y});
    end
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({busy, done, pix_valid} !== 3'b000) begin
      failures++; $display("FAIL post_reset_idle got=%b exp=000", {busy, done, pix_valid});
    end
  endtask

  task automatic test_degenerate();
    exp_q = '{16'h0505};
    start_line(8'd5, 8'd5, 8'd5, 8'd5);
    checks++;
    if ({busy, pix_valid} !== 2'b10) begin
      failures++; $display("FAIL degen_setup got=%b exp=10", {busy, pix_valid});
    end
    collect(32'hFFFF_FFFF, 20, -1);
    checks++;
    if (got_q.size() !== 1) begin
      failures++; $display("FAIL degen_count got=%0d exp=1", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL degen_pix%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_at !== last_hs + 1) begin
      failures++; $display("FAIL degen_done_lat got=%0d exp=%0d", done_at, last_hs + 1);
    end
    checks++;
    if ({busy, pix_valid} !== 2'b10) begin
      failures++; $display("FAIL degen_fin got=%b exp=10", {busy, pix_valid});
    end
    @(negedge ACLK);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL degen_after got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_horizontal();
    exp_q = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
    start_line(8'd0, 8'd0, 8'd3, 8'd0);
    collect(32'hFFFF_FFFF, 20, -1);
    checks++;
    if (first_v !== 1) begin
      failures++; $display("FAIL horiz_first_valid got=%0d exp=1", first_v);
    end
    checks++;
    if (got_q.size() !== 4 || last_hs !== 4) begin
      failures++; $display("FAIL horiz_count got=%0d/%0d exp=4/4", got_q.size(), last_hs);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL horiz_pix%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_at !== 5) begin
      failures++; $display("FAIL horiz_done_at got=%0d exp=5", done_at);
    end
    @(negedge ACLK);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL horiz_done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_steep_reversed();
    // Back-to-back: start issued in the IDLE cycle right after done.
    exp_q = '{16'h0000, 16'h0001, 16'h0102, 16'h0103};
    start_line(8'd0, 8'd0, 8'd1, 8'd3);
    collect(32'hFFFF_FFFF, 20, -1);
    checks++;
    if (got_q.size() !== 4) begin
      failures++; $display("FAIL steep_count got=%0d exp=4", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL steep_pix%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge ACLK);
    exp_q = '{16'h0303, 16'h0202, 16'h0101, 16'h0000};
    start_line(8'd3, 8'd3, 8'd0, 8'd0);
    collect(32'hFFFF_FFFF, 20, -1);
    checks++;
    if (got_q.size() !== 4) begin
      failures++; $display("FAIL rev_count got=%0d exp=4", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rev_pix%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge ACLK);
  endtask

  task automatic test_backpressure();
    logic [5:0]  rdy;
    logic [15:0] bp_exp [6];
    rdy = 6'b101001;
    bp_exp = '{16'h0000, 16'h0101, 16'h0101, 16'h0101, 16'h0201, 16'h0201};
    start_line(8'd0, 8'd0, 8'd2, 8'd1);
    @(negedge ACLK);
    for (int i = 0; i < 6; i++) begin
      pix_ready = rdy[i];
      checks++;
      if ({pix_valid, pix_x, pix_y} !== {1'b1, bp_exp[i]}) begin
        failures++;
        $display("FAIL bp_cycle%0d got=%b/%h exp=1/%h", i, pix_valid, {pix_x, pix_y}, bp_exp[i]);
      end
      @(negedge ACLK);
    end
    pix_ready = 1'b1;
    checks++;
    if ({done, pix_valid} !== 2'b10) begin
      failures++; $display("FAIL bp_done got=%b exp=10", {done, pix_valid});
    end
    @(negedge ACLK);
  endtask

  task automatic test_full_span();
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 8'(i)});
    start_line(8'd0, 8'd0, 8'd255, 8'd255);
    collect(32'hFFFF_FFFF, 300, 60);
    checks++;
    if (got_q.size() !== 256) begin
      failures++; $display("FAIL span_a_count got=%0d exp=256", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL span_a_pix%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge ACLK);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL span_a_ignored_start got=%b exp=0", busy);
    end
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(255 - i), 8'(i)});
    start_line(8'd255, 8'd0, 8'd0, 8'd255);
    collect(32'hFFFF_FFFF, 300, -1);
    checks++;
    if (got_q.size() !== 256) begin
      failures++; $display("FAIL span_b_count got=%0d exp=256", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL span_b_pix%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge ACLK);
  endtask

  task automatic test_reset_midline();
    int done_cnt;
    done_cnt = 0;
    start_line(8'd0, 8'd0, 8'd10, 8'd0);
    pix_ready = 1'b1;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({pix_valid, pix_x, pix_y} !== {1'b1, 16'h0200}) begin
      failures++; $display("FAIL rst_pre_pixel got=%b/%h exp=1/0200", pix_valid, {pix_x, pix_y});
    end
    ARESETn = 1'b0;
    #1;
    checks++;
    if ({busy, done, pix_valid, pix_x, pix_y} !== 19'd0) begin
      failures++;
      $display("FAIL rst_async got=%b%b%b/%h exp=000/0000", busy, done, pix_valid, {pix_x, pix_y});
    end
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (4) begin
      @(negedge ACLK);
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_no_done got=%0d/%b exp=0/0", done_cnt, busy);
    end
    exp_q = '{16'h0102, 16'h0202, 16'h0302, 16'h0402};
    start_line(8'd1, 8'd2, 8'd4, 8'd2);
    collect(32'hFFFF_FFFF, 20, -1);
    checks++;
    if (got_q.size() !== 4) begin
      failures++; $display("FAIL rst_new_count got=%0d exp=4", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rst_new_pix%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge ACLK);
  endtask

  initial begin
    ARESETn = 1'b1;
    start = 1'b0; pix_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    test_reset();
    test_degenerate();
    test_horizontal();
    test_steep_reversed();
    test_backpressure();
    test_full_span();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_rasterizer.md
Name: line_rasterizer

Overview:
- Bresenham line generator that sits directly downstream of the render unit's object decoder.
- Accepts one line segment (two 8-bit endpoints) per start pulse.
- Emits the segment's pixel coordinates one per handshake on a valid/ready stream toward the pixel writer.
- Signals completion so the render unit can fetch the next object.

Parameters:
- COORD_W, 8, width of every coordinate (x and y, in and out).

Ports:
- ACLK  input  1  system clock, all state on rising edge
- ARESETn  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to rasterize; sampled only in IDLE
- x0  input  COORD_W  start point x, captured when start accepted
- y0  input  COORD_W  start point y
- x1  input  COORD_W  end point x
- y1  input  COORD_W  end point y
- busy  output  1  high from the cycle after start acceptance until done pulse inclusive
- done  output  1  one-cycle pulse after the last pixel handshake
- pix_valid  output  1  pix_x/pix_y hold a valid pixel
- pix_ready  input  1  downstream accepts pixel when pix_valid and pix_ready are both high
- pix_x  output  COORD_W  pixel x
- pix_y  output  COORD_W  pixel y

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE.
  - busy, done, pix_valid = 0; pix_x, pix_y = 0.
  - Internal registers cleared.
  - Reset mid-line abandons the line; no done pulse is produced.
- States: IDLE, SETUP, EMIT, FIN.
- IDLE:
  - When start = 1, latch x0/y0/x1/y1 and go to SETUP.
  - start in any other state is ignored (no queueing).
- SETUP (1 cycle):
  - dx = |x1-x0|, dy = -|y1-y0|.
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1.
  - err = dx+dy.
  - Current point = (x0, y0).
  - Next state EMIT with pix_valid = 1.
- Arithmetic width:
  - dx, dy, err are signed COORD_W+2 bits.
  - e2 = 2*err is signed COORD_W+3 bits.
  - No overflow is permitted for any 8-bit endpoint pair.
  - Coordinates never wrap: stepping stops exactly at (x1, y1).
- EMIT:
  - pix_x/pix_y = current point; pix_valid = 1.
  - While pix_ready = 0, outputs and internal state hold stable (no change until accepted).
  - On handshake, if current point == (x1, y1): drop pix_valid and go to FIN.
  - On handshake otherwise:
    - e2 = 2*err.
    - If e2 >= dy: err += dy, x += sx.
    - If e2 <= dx: err += dx, y += sy.
    - Both updates are applied in the same cycle when both conditions hold.
    - New point is presented the next cycle; pix_valid stays 1, giving one pixel per cycle under constant ready.
- FIN:
  - done = 1 for exactly one cycle; busy = 1 in this cycle.
  - Next state IDLE.
  - start is accepted in the cycle after done (i.e. when back in IDLE).
- Latency:
  - start sampled at edge N → first pix_valid visible after edge N+2.
  - Last handshake at edge M → done high after edge M+1.
- Pixel count = max(dx, |dy|) + 1.
- Degenerate segment (x0 = x1, y0 = y1): exactly one pixel, then done.
- busy is 0 in IDLE and 1 in SETUP, EMIT and FIN.
- pix_valid is 1 only in EMIT.

Test Plan:
- Reset then (5,5)->(5,5), pix_ready = 1 → one pixel (5,5); done 1 cycle after its handshake; busy low the following cycle.
- (0,0)->(3,0), pix_ready = 1 → pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles; first pix_valid 2 cycles after start.
- Steep line (0,0)->(1,3) → (0,0),(0,1),(1,2),(1,3). Reversed line (3,3)->(0,0) → (3,3),(2,2),(1,1),(0,0).
- (0,0)->(2,1) with pix_ready toggling 1,0,0,1,0,1 → pix_x/pix_y/pix_valid stable while ready is low; sequence (0,0),(1,1),(2,1); no pixel duplicated or skipped.
- Full span (0,0)->(255,255) and (255,0)->(0,255) → 256 pixels each, ending exactly at the endpoint, no coordinate wrap. A start pulse asserted mid-line is ignored.
- ARESETn low during the 3rd pixel of (0,0)->(10,0) → all outputs 0 immediately; no done pulse. A new start after release rasterizes its new line from the first pixel.
